// File: rtl/gate_sensor_decoder_if.sv
// Gate sensor decoder bus: raw beam inputs and qualified
// entry/exit events with occupancy status.
interface gate_sensor_decoder_if #(
  parameter int CNT_W = 4
);
  logic             sensor_outer;
  logic             sensor_inner;
  logic             enter;
  logic             exit;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             seq_error;

  modport master (
    output sensor_outer,
    output sensor_inner,
    input  enter,
    input  exit,
    input  occupancy,
    input  full,
    input  empty,
    input  seq_error
  );

  modport slave (
    input  sensor_outer,
    input  sensor_inner,
    output enter,
    output exit,
    output occupancy,
    output full,
    output empty,
    output seq_error
  );
endinterface

// File: rtl/gate_sensor_decoder.sv
// Gate front-end: synchronise and debounce two beam sensors,
// decode travel direction, keep a saturating occupancy count.
module gate_sensor_decoder #(
  parameter int DEBOUNCE = 4,
  parameter int CAPACITY = 9,
  parameter int CNT_W    = 4
) (
  input logic clock,
  input logic reset_n,
  gate_sensor_decoder_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CAP_M1 = CNT_W'(CAPACITY - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_BA,
    OUT_A
  } state_t;

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [DW-1:0] cnt [2];
  logic          upd;

  state_t           state;
  logic [CNT_W-1:0] occ;
  logic             enter_q;
  logic             exit_q;
  logic             err_q;
  logic             full_q;
  logic             empty_q;

  assign raw = {bus.sensor_outer, bus.sensor_inner};

  // bit 1 = outer beam, bit 0 = inner beam
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
      upd    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      upd   <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == filt[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == DB_LAST) begin
          filt[k] <= sync2[k];
          cnt[k]  <= '0;
          upd     <= 1'b1;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // The FSM only acts on a fresh filtered pair, so a held
  // illegal pattern reports a single error pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      occ     <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
      if (upd) begin
        unique case (state)
          IDLE: begin
            case (filt)
              2'b10: state <= IN_A;
              2'b01: state <= OUT_B;
              2'b11: err_q <= 1'b1;
              default: ;
            endcase
          end
          IN_A: begin
            case (filt)
              2'b11: state <= IN_AB;
              2'b00: state <= IDLE;
              2'b01: begin
                state <= IDLE;
                err_q <= 1'b1;
              end
              default: ;
            endcase
          end
          IN_AB: begin
            case (filt)
              2'b01: state <= IN_B;
              2'b10: state <= IN_A;
              2'b00: begin
                state <= IDLE;
                err_q <= 1'b1;
              end
              default: ;
            endcase
          end
          IN_B: begin
            case (filt)
              2'b11: state <= IN_AB;
              2'b10: begin
                state <= IDLE;
                err_q <= 1'b1;
              end
              2'b00: begin
                state   <= IDLE;
                enter_q <= 1'b1;
                if (full_q) begin
                  err_q <= 1'b1;
                end else begin
                  occ     <= occ + ONE;
                  full_q  <= (occ == CAP_M1);
                  empty_q <= 1'b0;
                end
              end
              default: ;
            endcase
          end
          OUT_B: begin
            case (filt)
              2'b11: state <= OUT_BA;
              2'b00: state <= IDLE;
              2'b10: begin
                state <= IDLE;
                err_q <= 1'b1;
              end
              default: ;
            endcase
          end
          OUT_BA: begin
            case (filt)
              2'b10: state <= OUT_A;
              2'b01: state <= OUT_B;
              2'b00: begin
                state <= IDLE;
                err_q <= 1'b1;
              end
              default: ;
            endcase
          end
          OUT_A: begin
            case (filt)
              2'b11: state <= OUT_BA;
              2'b01: begin
                state <= IDLE;
                err_q <= 1'b1;
              end
              2'b00: begin
                state  <= IDLE;
                exit_q <= 1'b1;
                if (empty_q) begin
                  err_q <= 1'b1;
                end else begin
                  occ     <= occ - ONE;
                  empty_q <= (occ == ONE);
                  full_q  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.enter     = enter_q;
  assign bus.exit      = exit_q;
  assign bus.seq_error = err_q;
  assign bus.occupancy = occ;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed bench for gate_sensor_decoder: table of sensor
// phases with expected pulse counts and occupancy.
module tb_gate_sensor_decoder;

  localparam int CAP = 9;

  typedef struct {
    bit o;
    bit i;
    int hold;
    int n_en;
    int n_ex;
    int n_er;
    int occ;
  } vec_t;

  logic clock;
  logic reset_n;

  gate_sensor_decoder_if #(.CNT_W(4)) bus ();

  gate_sensor_decoder #(
    .DEBOUNCE(4),
    .CAPACITY(CAP),
    .CNT_W(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  vec_t vecs[$];
  int tests;
  int failed;
  int ne;
  int nx;
  int nr;
  int bad;

  function automatic void add(bit o, bit i, int h,
                              int en, int ex, int er,
                              int oc);
    vec_t v;
    v.o = o;
    v.i = i;
    v.hold = h;
    v.n_en = en;
    v.n_ex = ex;
    v.n_er = er;
    v.occ = oc;
    vecs.push_back(v);
  endfunction

  function automatic void add_entry(int b, int a, int er);
    add(1, 0, 10, 0, 0, 0, b);
    add(1, 1, 10, 0, 0, 0, b);
    add(0, 1, 10, 0, 0, 0, b);
    add(0, 0, 10, 1, 0, er, a);
  endfunction

  function automatic void add_exit(int b, int a, int er);
    add(0, 1, 10, 0, 0, 0, b);
    add(1, 1, 10, 0, 0, 0, b);
    add(1, 0, 10, 0, 0, 0, b);
    add(0, 0, 10, 0, 1, er, a);
  endfunction

  task automatic check(string name, int idx,
                       int act, int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %0d, expected %0d",
               name, idx, act, exp);
    end
  endtask

  // Drive a sensor level and count pulses, flagging wide or
  // overlapping pulses.
  task automatic run(bit o, bit i, int hold);
    bit pe;
    bit px;
    bit pr;
    bus.sensor_outer = o;
    bus.sensor_inner = i;
    ne = 0;
    nx = 0;
    nr = 0;
    bad = 0;
    pe = 0;
    px = 0;
    pr = 0;
    for (int c = 0; c < hold; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.enter) ne++;
      if (bus.exit) nx++;
      if (bus.seq_error) nr++;
      if (bus.enter && pe) bad++;
      if (bus.exit && px) bad++;
      if (bus.seq_error && pr) bad++;
      if (bus.enter && bus.exit) bad++;
      pe = bus.enter;
      px = bus.exit;
      pr = bus.seq_error;
    end
  endtask

  initial begin
    int lat;
    tests = 0;
    failed = 0;

    add(0, 0, 20, 0, 0, 0, 0);
    add_entry(0, 1, 0);
    add_exit(1, 0, 0);
    add(1, 0, 3, 0, 0, 0, 0);
    add(0, 0, 10, 0, 0, 0, 0);
    add(1, 0, 10, 0, 0, 0, 0);
    add(0, 0, 10, 0, 0, 0, 0);
    add(1, 1, 10, 0, 0, 1, 0);
    add(0, 1, 10, 0, 0, 0, 0);
    add(0, 0, 10, 0, 0, 0, 0);
    add(1, 0, 10, 0, 0, 0, 0);
    add(0, 1, 10, 0, 0, 1, 0);
    add(0, 0, 10, 0, 0, 0, 0);
    for (int k = 0; k < CAP; k++) add_entry(k, k + 1, 0);
    add_entry(CAP, CAP, 1);
    for (int k = CAP; k > 0; k--) add_exit(k, k - 1, 0);
    add_exit(0, 0, 1);

    reset_n = 1'b0;
    bus.sensor_outer = 1'b0;
    bus.sensor_inner = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_occ", 0, int'(bus.occupancy), 0);
    check("rst_empty", 0, int'(bus.empty), 1);
    check("rst_full", 0, int'(bus.full), 0);
    check("rst_pulse", 0,
          int'(bus.enter | bus.exit | bus.seq_error), 0);
    reset_n = 1'b1;

    foreach (vecs[n]) begin
      run(vecs[n].o, vecs[n].i, vecs[n].hold);
      check("enter_cnt", n, ne, vecs[n].n_en);
      check("exit_cnt", n, nx, vecs[n].n_ex);
      check("err_cnt", n, nr, vecs[n].n_er);
      check("pulse_shape", n, bad, 0);
      check("occ", n, int'(bus.occupancy), vecs[n].occ);
      check("full", n, int'(bus.full),
            int'(vecs[n].occ == CAP));
      check("empty", n, int'(bus.empty),
            int'(vecs[n].occ == 0));
    end

    run(1, 0, 10);
    run(1, 1, 10);
    run(0, 1, 10);
    bus.sensor_outer = 1'b0;
    bus.sensor_inner = 1'b0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.enter) begin
        lat = c;
        break;
      end
    end
    check("enter_latency", 0, lat, 7);
    check("lat_occ", 0, int'(bus.occupancy), 1);
    @(posedge clock);
    @(negedge clock);
    check("enter_width", 0, int'(bus.enter), 0);

    run(1, 0, 10);
    run(1, 1, 10);
    reset_n = 1'b0;
    bus.sensor_outer = 1'b0;
    bus.sensor_inner = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    run(0, 0, 20);
    check("mid_rst_enter", 0, ne, 0);
    check("mid_rst_err", 0, nr, 0);
    check("mid_rst_occ", 0, int'(bus.occupancy), 0);
    check("mid_rst_empty", 0, int'(bus.empty), 1);

    run(1, 0, 10);
    run(1, 1, 10);
    run(0, 1, 10);
    run(0, 0, 10);
    check("post_rst_enter", 0, ne, 1);
    check("post_rst_occ", 0, int'(bus.occupancy), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gate_sensor_decoder.md
Name: gate_sensor_decoder

Overview:
- Front-end stage feeding the parking controller: turns two raw light-beam sensors at the gate into clean one-cycle enter/exit event pulses.
- Beam order gives the direction of travel: outer beam then inner beam is an entry; inner then outer is an exit.
- Keeps an occupancy count, full/empty flags and an error pulse for illegal beam sequences, so the controller and HEX displays get qualified events only.

Parameters:
- DEBOUNCE, 4, consecutive stable cycles (after synchroniser) needed before a filtered sensor value changes; minimum 1.
- CAPACITY, 9, number of parking spaces; full when occupancy equals this value.
- CNT_W, 4, occupancy width; must hold CAPACITY.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sensor_outer  in  1  raw outer beam, 1 = blocked, asynchronous.
- sensor_inner  in  1  raw inner beam, 1 = blocked, asynchronous.
- enter  out  1  one-cycle pulse on each completed entry.
- exit  out  1  one-cycle pulse on each completed exit.
- occupancy  out  CNT_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- seq_error  out  1  one-cycle pulse on an illegal sequence, an overflow or an underflow.

Behaviour:
- Reset (reset_n low at a rising edge):
  - Synchronisers, filtered values and debounce counters go to 0.
  - FSM goes to IDLE and occupancy goes to 0.
  - Outputs: enter=0, exit=0, seq_error=0, full=0, empty=1.
  - Reset mid-sequence abandons the sequence with no event pulse.
- Input path:
  - Each sensor passes through a 2-FF synchroniser, then a debouncer.
  - Debouncer counter clears whenever the synchronised value equals the filtered value.
  - Otherwise the counter increments; on reaching DEBOUNCE, the filtered value takes the new value and the counter clears.
  - Result: a raw change held stable changes the filtered value 2+DEBOUNCE edges later.
  - Glitches shorter than DEBOUNCE cycles never reach the FSM.
- FSM state encodes the filtered pair {outer,inner}. States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A.
- From IDLE:
  - 10 -> IN_A; 01 -> OUT_B.
  - 11 -> stay IDLE and pulse seq_error.
- Entry states:
  - IN_A: 11 -> IN_AB; 00 -> IDLE with no event (car backed out); 01 -> IDLE + seq_error.
  - IN_AB: 01 -> IN_B; 10 -> IN_A; 00 -> IDLE + seq_error.
  - IN_B: 11 -> IN_AB; 10 -> IDLE + seq_error.
  - IN_B on 00 -> IDLE, enter pulse, and occupancy+1 if not full.
  - If already full at that point: enter still pulses, occupancy holds at CAPACITY, and seq_error pulses in the same cycle.
- Exit states (mirror of entry):
  - OUT_B: 11 -> OUT_BA; 00 -> IDLE with no event; 10 -> IDLE + seq_error.
  - OUT_BA: 10 -> OUT_A; 01 -> OUT_B; 00 -> IDLE + seq_error.
  - OUT_A: 11 -> OUT_BA; 01 -> IDLE + seq_error.
  - OUT_A on 00 -> IDLE, exit pulse, and occupancy-1 if not empty.
  - If already empty at that point: exit still pulses, occupancy holds at 0, and seq_error pulses.
- Pulse timing:
  - enter, exit and seq_error are registered.
  - Each is high for exactly one cycle, on the edge after the filtered value that triggers the transition.
  - enter and exit are never high in the same cycle.
- Occupancy:
  - Saturates at 0 and CAPACITY; it never wraps.
  - Updates in the same cycle as its pulse.
  - full and empty are registered and consistent with occupancy in every cycle.
- Both filtered bits may change in the same cycle; the transition is decided purely on the new pair, per the tables above.

Test Plan:
- Reset, then idle:
  - Hold reset_n=0 for 5 cycles with both sensors 0.
  - Required: occupancy=0, empty=1, full=0, and no pulses for 20 cycles after reset_n=1.
- Clean entry (DEBOUNCE=4, each sensor level held 10 cycles):
  - Drive outer=1; then inner=1; then outer=0; then inner=0.
  - Required: exactly one enter pulse, 1 cycle wide, 7 edges after inner falls; occupancy 0->1; empty drops.
- Clean exit after one entry:
  - Drive inner=1, then outer=1, then inner=0, then outer=0.
  - Required: one exit pulse; occupancy 1->0; empty=1; no seq_error.
- Glitch and back-out:
  - 3-cycle pulse on outer: no state change.
  - outer=1 for 10 cycles then 0: no enter, no seq_error, occupancy unchanged.
- Saturation, CAPACITY=9:
  - Perform 10 entries. Required: 10th gives enter and seq_error together, occupancy stays 9, full=1.
  - Then perform 1 exit. Required: occupancy=8, full=0.
  - Repeating exits from 0 gives exit plus seq_error, with occupancy staying 0.
- Illegal sequence and mid-sequence reset:
  - From IDLE, both sensors rise together: seq_error pulse, state stays IDLE.
  - Drop reset_n during IN_AB, then release with sensors 00: no enter pulse, occupancy=0.
